// File: rtl/io_bank_sync_filter.sv
// Bank of WIDTH bidirectional pins: registered tri-state drive, synchronised and glitch-filtered
// readback with rise/fall pulses. Define IO_IRQ_LATCH_EN to add sticky edge flags and a masked irq.
module io_bank_sync_filter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned FILTER_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] IO_pin,
  input  logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_oe,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef IO_IRQ_LATCH_EN
  ,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
`endif
);

  localparam int unsigned   CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("io_bank_sync_filter: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_bank_sync_filter: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_filter
    $error("io_bank_sync_filter: FILTER_CYCLES must be 1..65535");
  end

  // Output path
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;

  // Async reset releases the pins immediately, not on the next clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= data_out;
      oe_q  <= data_oe;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign IO_pin[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

  // Input synchroniser; samples the pin whether or not this bank drives it
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= IO_pin;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Glitch filter: any cycle of agreement restarts the stability count
  logic [CW-1:0] cnt_q [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in <= '0;
      rise    <= '0;
      fall    <= '0;
      for (int unsigned c = 0; c < WIDTH; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        rise[c] <= 1'b0;
        fall[c] <= 1'b0;
        if (s[c] == data_in[c]) begin
          cnt_q[c] <= '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          data_in[c] <= s[c];
          cnt_q[c]   <= '0;
          rise[c]    <= s[c];
          fall[c]    <= ~s[c];
        end else begin
          cnt_q[c] <= cnt_q[c] + CW'(1);
        end
      end
    end
  end

`ifdef IO_IRQ_LATCH_EN
  // Set beats clear; mask only gates the irq output, never the status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | rise | fall;
      irq        <= |(irq_status & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_io_bank_sync_filter.sv
// Directed bench for io_bank_sync_filter: default instance (latency 4) and a FILTER_CYCLES=5 instance.
module tb_io_bank_sync_filter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a_drv, a_en, b_drv, b_en;
  wire  [7:0] pin_a, pin_b;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pin_a[i] = a_en[i] ? a_drv[i] : 1'bz;
    assign pin_b[i] = b_en[i] ? b_drv[i] : 1'bz;
  end

  logic [7:0] out_a, oe_a, in_a, rise_a, fall_a;
  logic [7:0] out_b, oe_b, in_b, rise_b, fall_b;
`ifdef IO_IRQ_LATCH_EN
  logic [7:0] mask_a, clr_a, stat_a, mask_b, clr_b, stat_b;
  logic       irq_a, irq_b;
`endif

  io_bank_sync_filter u_dut_a (
    .clk(clk), .rst_n(rst_n), .IO_pin(pin_a),
    .data_out(out_a), .data_oe(oe_a), .data_in(in_a), .rise(rise_a), .fall(fall_a)
`ifdef IO_IRQ_LATCH_EN
    , .irq_mask(mask_a), .irq_clr(clr_a), .irq_status(stat_a), .irq(irq_a)
`endif
  );

  io_bank_sync_filter #(.WIDTH(8), .SYNC_STAGES(3), .FILTER_CYCLES(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .IO_pin(pin_b),
    .data_out(out_b), .data_oe(oe_b), .data_in(in_b), .rise(rise_b), .fall(fall_b)
`ifdef IO_IRQ_LATCH_EN
    , .irq_mask(mask_b), .irq_clr(clr_b), .irq_status(stat_b), .irq(irq_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_en = 8'hFF; a_drv = 8'h00;
    #2;
    n_tests++;
    if (pin_a !== 8'h00) begin n_fail++; $display("FAIL reset_pin_released: got %h expected %h", pin_a, 8'h00); end
    a_en = 8'h00;
    tick(); tick();
    n_tests++;
    if (in_a !== 8'h00 || rise_a !== 8'h00 || fall_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got in=%h rise=%h fall=%h expected 00 00 00", in_a, rise_a, fall_a);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (pin_a !== 8'hFF) begin n_fail++; $display("FAIL release_drive: got %h expected %h", pin_a, 8'hFF); end
    rst_n = 1'b0;
    #1 a_en = 8'hFF;
    #1;
    n_tests++;
    if (pin_a !== 8'h00) begin n_fail++; $display("FAIL async_release: got %h expected %h", pin_a, 8'h00); end
    oe_a = 8'h00;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tests++;
      if (in_a !== 8'h00 || rise_a !== 8'h00 || in_b !== 8'h00) begin
        n_fail++; $display("FAIL idle_after_reset k=%0d: got in_a=%h rise_a=%h in_b=%h expected 00", k, in_a, rise_a, in_b);
      end
    end
  endtask

  task automatic test_latency;
    logic [7:0] e_in, e_rise, e_fall;
    a_drv[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_in   = (k >= 4) ? 8'h01 : 8'h00;
      e_rise = (k == 4) ? 8'h01 : 8'h00;
      n_tests++;
      if (in_a !== e_in || rise_a !== e_rise || fall_a !== 8'h00) begin
        n_fail++; $display("FAIL latency_rise k=%0d: got in=%h rise=%h fall=%h expected %h %h 00", k, in_a, rise_a, fall_a, e_in, e_rise);
      end
    end
    a_drv[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_in   = (k >= 4) ? 8'h00 : 8'h01;
      e_fall = (k == 4) ? 8'h01 : 8'h00;
      n_tests++;
      if (in_a !== e_in || fall_a !== e_fall || rise_a !== 8'h00) begin
        n_fail++; $display("FAIL latency_fall k=%0d: got in=%h fall=%h rise=%h expected %h %h 00", k, in_a, fall_a, rise_a, e_in, e_fall);
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] e_in, e_rise, e_fall;
    b_drv[3] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) b_drv[3] = 1'b0;
      n_tests++;
      if (in_b !== 8'h00 || rise_b !== 8'h00 || fall_b !== 8'h00) begin
        n_fail++; $display("FAIL glitch_4cyc k=%0d: got in=%h rise=%h fall=%h expected 00 00 00", k, in_b, rise_b, fall_b);
      end
    end
    b_drv[3] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) b_drv[3] = 1'b0;
      e_in   = (k >= 8 && k < 13) ? 8'h08 : 8'h00;
      e_rise = (k == 8)  ? 8'h08 : 8'h00;
      e_fall = (k == 13) ? 8'h08 : 8'h00;
      n_tests++;
      if (in_b !== e_in || rise_b !== e_rise || fall_b !== e_fall) begin
        n_fail++; $display("FAIL pulse_5cyc k=%0d: got in=%h rise=%h fall=%h expected %h %h %h", k, in_b, rise_b, fall_b, e_in, e_rise, e_fall);
      end
    end
  endtask

  task automatic test_drive_readback;
    logic e_in, e_edge;
    out_a[2] = 1'b0; oe_a[2] = 1'b1;
    tick();
    a_en[2] = 1'b0;
    tick();
    for (int t = 0; t < 2; t++) begin
      out_a[2] = (t == 0);
      #1;
      n_tests++;
      if (pin_a[2] !== (t != 0)) begin n_fail++; $display("FAIL drive_before_edge t=%0d: got %b expected %b", t, pin_a[2], (t != 0)); end
      for (int k = 1; k <= 5; k++) begin
        tick();
        e_in   = (k >= 5) ? (t == 0) : (t != 0);
        e_edge = (k == 5);
        n_tests++;
        if (pin_a[2] !== (t == 0) || in_a[2] !== e_in || (t == 0 ? rise_a[2] : fall_a[2]) !== e_edge) begin
          n_fail++; $display("FAIL drive_readback t=%0d k=%0d: got pin=%b in=%b rise=%b fall=%b expected pin=%b in=%b edge=%b",
                             t, k, pin_a[2], in_a[2], rise_a[2], fall_a[2], (t == 0), e_in, e_edge);
        end
      end
    end
    a_en[2] = 1'b1; a_drv[2] = 1'b0;
    tick();
    oe_a[2] = 1'b0;
    tick();
  endtask

  task automatic test_all_channels;
    logic [7:0] e_in, e_rise, e_fall;
    a_drv = 8'hA5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_in   = (k >= 4) ? 8'hA5 : 8'h00;
      e_rise = (k == 4) ? 8'hA5 : 8'h00;
      n_tests++;
      if (in_a !== e_in || rise_a !== e_rise || fall_a !== 8'h00) begin
        n_fail++; $display("FAIL all_rise k=%0d: got in=%h rise=%h fall=%h expected %h %h 00", k, in_a, rise_a, fall_a, e_in, e_rise);
      end
    end
    a_drv = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_in   = (k >= 4) ? 8'h00 : 8'hA5;
      e_fall = (k == 4) ? 8'hA5 : 8'h00;
      n_tests++;
      if (in_a !== e_in || fall_a !== e_fall || rise_a !== 8'h00) begin
        n_fail++; $display("FAIL all_fall k=%0d: got in=%h fall=%h rise=%h expected %h %h 00", k, in_a, fall_a, rise_a, e_in, e_fall);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e_in, e_rise;
    b_drv[5] = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_b !== 8'h00 || rise_b !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_clear: got in=%h rise=%h expected 00 00", in_b, rise_b);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e_in   = (k >= 8) ? 8'h20 : 8'h00;
      e_rise = (k == 8) ? 8'h20 : 8'h00;
      n_tests++;
      if (in_b !== e_in || rise_b !== e_rise) begin
        n_fail++; $display("FAIL mid_reset_relatch k=%0d: got in=%h rise=%h expected %h %h", k, in_b, rise_b, e_in, e_rise);
      end
    end
  endtask

`ifdef IO_IRQ_LATCH_EN
  task automatic test_irq;
    n_tests++;
    if (stat_a !== 8'h00 || irq_a !== 1'b0) begin
      n_fail++; $display("FAIL irq_reset: got status=%h irq=%b expected 00 0", stat_a, irq_a);
    end
    mask_a = 8'h01;
    a_drv[1] = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    n_tests++;
    if (stat_a !== 8'h02 || irq_a !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked_edge: got status=%h irq=%b expected 02 0", stat_a, irq_a);
    end
    a_drv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    clr_a = 8'h01;
    tick();
    clr_a = 8'h00;
    n_tests++;
    if (stat_a !== 8'h03) begin n_fail++; $display("FAIL irq_set_wins: got status=%h expected 03", stat_a); end
    tick();
    n_tests++;
    if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b expected 1", irq_a); end
    clr_a = 8'h03;
    tick();
    clr_a = 8'h00;
    n_tests++;
    if (stat_a !== 8'h00) begin n_fail++; $display("FAIL irq_clear: got status=%h expected 00", stat_a); end
    tick();
    n_tests++;
    if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: got %b expected 0", irq_a); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a_en = 8'h00; a_drv = 8'h00; out_a = 8'hFF; oe_a = 8'hFF;
    b_en = 8'hFF; b_drv = 8'h00; out_b = 8'h00; oe_b = 8'h00;
`ifdef IO_IRQ_LATCH_EN
    mask_a = 8'h00; clr_a = 8'h00; mask_b = 8'h00; clr_b = 8'h00;
`endif
    test_reset();
    test_latency();
    test_glitch();
    test_drive_readback();
    test_all_channels();
    test_reset_mid();
`ifdef IO_IRQ_LATCH_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
